lsu_bus_router: RTL and testbench

Parametrised load/store router between the RV32I MEM stage, the local data memory and the AXI master bridge. Internal-window accesses pass straight through to DMEM. External accesses are decoded, latched and issued as a single outstanding transaction with byte strobes, and the pipeline is stalled until completion. Load results are sign/zero-extended and written back on a dedicated port, with misalign and timeout error reporting.

---
 rtl/lsu_bus_router_if.sv | 25 ++
 rtl/lsu_bus_router.sv | 236 +++++++++++++++++++++++
 tb/tb_lsu_bus_router.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_router_if.sv
// Router <-> AXI master bridge link: one outstanding transaction with byte strobes.
// The router uses the master modport; the bridge side uses slave.
interface lsu_bus_router_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    logic              axi_init_o;
    logic [XLEN-1:0]   axi_addr_o;
    logic [XLEN-1:0]   axi_data_w_o;
    logic              axi_we_o;
    logic [STRB_W-1:0] axi_strb_o;
    logic              axi_done_i;
    logic              axi_err_i;
    logic [XLEN-1:0]   axi_rdata_i;

    modport master (
        output axi_init_o, axi_addr_o, axi_data_w_o, axi_we_o, axi_strb_o,
        input  axi_done_i, axi_err_i, axi_rdata_i
    );

    modport slave (
        input  axi_init_o, axi_addr_o, axi_data_w_o, axi_we_o, axi_strb_o,
        output axi_done_i, axi_err_i, axi_rdata_i
    );
endinterface

// File: rtl/lsu_bus_router.sv
// MEM-stage load/store router: internal window to DMEM, everything else to the AXI bridge.
// Optional WAIT timeout is built when LSU_ROUTER_TIMEOUT_EN is defined.
module lsu_bus_router #(
    parameter int unsigned RV32I_DMEM_DEPTH = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_w_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  addr_d_i,
    input  logic        reg_we_i,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_data_w_o,
    output logic        dmem_mem_we_o,
    output logic        dmem_mem_re_o,
    output logic [2:0]  dmem_funct3_o,
    lsu_bus_router_if.master bus,
    output logic        stall_o,
    output logic        reg_we_o,
    output logic [4:0]  addr_d_o,
    output logic        ext_wb_we_o,
    output logic [4:0]  ext_wb_addr_o,
    output logic [31:0] ext_wb_data_o,
    output logic        bus_err_o
);
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [31:0] DMEM_MAX = 32'(RV32I_DMEM_DEPTH * 1024 - 1);
    localparam int unsigned CNT_W    = 8;

    // Out-of-range timeout limit is a build error, not a silent wrap
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("lsu_bus_router: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_nx;
    logic        init_q, init_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] data_q, data_nx;
    logic        we_q, we_nx;
    logic [3:0]  strb_q, strb_nx;
    logic [2:0]  f3_q, f3_nx;
    logic [4:0]  rd_q, rd_nx;
    logic        wb_we_q, wb_we_nx;
    logic [4:0]  wb_addr_q, wb_addr_nx;
    logic [31:0] wb_data_q, wb_data_nx;
    logic        err_q, err_nx;

    logic        is_load, is_store, ls, ext, misalign, ext_valid;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign is_load   = (opcode_i == OP_LOAD);
    assign is_store  = (opcode_i == OP_STORE);
    assign ls        = is_load || is_store;
    assign ext       = (addr_i > DMEM_MAX);
    assign misalign  = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign ext_valid = ls && ext && !misalign;

    // Internal DMEM path, zeroed unless this is an internal-window access
    assign dmem_addr_o   = (ls && !ext) ? addr_i   : 32'd0;
    assign dmem_data_w_o = (ls && !ext) ? data_w_i : 32'd0;
    assign dmem_mem_we_o = ls && !ext && mem_we_i;
    assign dmem_mem_re_o = ls && !ext && mem_re_i;
    assign dmem_funct3_o = (ls && !ext) ? funct3_i : 3'd0;

    // External loads write back through the dedicated port; misaligned accesses never write
    assign reg_we_o = (ls && (ext || misalign)) ? 1'b0 : reg_we_i;
    assign addr_d_o = (ls && (ext || misalign)) ? 5'd0 : addr_d_i;

    assign bus.axi_init_o   = init_q;
    assign bus.axi_addr_o   = addr_q;
    assign bus.axi_data_w_o = data_q;
    assign bus.axi_we_o     = we_q;
    assign bus.axi_strb_o   = strb_q;
    assign ext_wb_we_o      = wb_we_q;
    assign ext_wb_addr_o    = wb_addr_q;
    assign ext_wb_data_o    = wb_data_q;
    assign bus_err_o        = err_q;

    // Store lane placement: narrow data replicated across every lane it may land on
    always_comb begin
        st_strb = 4'b1111;
        st_data = data_w_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr_i[1:0];
                st_data = {4{data_w_i[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {addr_i[1], 1'b0};
                st_data = {2{data_w_i[15:0]}};
            end
            default: ;
        endcase
        if (!is_store) begin
            st_strb = 4'b0000;
            st_data = 32'd0;
        end
    end

    // Load extraction and extension from the raw bridge word
    always_comb begin
        ld_byte = bus.axi_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.axi_rdata_i[31:16] : bus.axi_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = bus.axi_rdata_i;
        endcase
    end

`ifdef LSU_ROUTER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_nx;
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_nx   = state_q;
        init_nx    = 1'b0;
        addr_nx    = addr_q;
        data_nx    = data_q;
        we_nx      = we_q;
        strb_nx    = strb_q;
        f3_nx      = f3_q;
        rd_nx      = rd_q;
        wb_we_nx   = 1'b0;
        wb_addr_nx = 5'd0;
        wb_data_nx = 32'd0;
        err_nx     = 1'b0;
        stall_o    = 1'b0;
`ifdef LSU_ROUTER_TIMEOUT_EN
        cnt_nx     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ext_valid) begin
                    stall_o   = 1'b1;
                    init_nx   = 1'b1;
                    addr_nx   = addr_i;
                    data_nx   = st_data;
                    we_nx     = is_store;
                    strb_nx   = st_strb;
                    f3_nx     = funct3_i;
                    rd_nx     = addr_d_i;
                    state_nx  = S_ISSUE;
                end else if (ls && ext && misalign) begin
                    err_nx = 1'b1;
                end
            end
            S_ISSUE: begin
                stall_o  = 1'b1;
                state_nx = S_WAIT;
`ifdef LSU_ROUTER_TIMEOUT_EN
                cnt_nx   = '0;
`endif
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (bus.axi_done_i) begin
                    state_nx = S_DONE;
                    if (bus.axi_err_i) begin
                        err_nx = 1'b1;
                    end else if (!we_q) begin
                        wb_we_nx   = 1'b1;
                        wb_addr_nx = rd_q;
                        wb_data_nx = ld_ext;
                    end
                end else if (timeout) begin
                    state_nx = S_DONE;
                    err_nx   = 1'b1;
                end else begin
`ifdef LSU_ROUTER_TIMEOUT_EN
                    cnt_nx = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            we_q      <= 1'b0;
            strb_q    <= 4'd0;
            f3_q      <= 3'd0;
            rd_q      <= 5'd0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nx;
            init_q    <= init_nx;
            addr_q    <= addr_nx;
            data_q    <= data_nx;
            we_q      <= we_nx;
            strb_q    <= strb_nx;
            f3_q      <= f3_nx;
            rd_q      <= rd_nx;
            wb_we_q   <= wb_we_nx;
            wb_addr_q <= wb_addr_nx;
            wb_data_q <= wb_data_nx;
            err_q     <= err_nx;
        end
    end
endmodule

// File: tb/tb_lsu_bus_router.sv
// Scoreboard bench for lsu_bus_router: stimulus pushes expected bridge/writeback/error
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_bus_router;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode_i;
    logic [31:0] addr_i, data_w_i;
    logic [2:0]  funct3_i;
    logic [4:0]  addr_d_i;
    logic        reg_we_i, mem_we_i, mem_re_i;
    logic [31:0] dmem_addr_o, dmem_data_w_o;
    logic        dmem_mem_we_o, dmem_mem_re_o;
    logic [2:0]  dmem_funct3_o;
    logic        stall_o, reg_we_o;
    logic [4:0]  addr_d_o;
    logic        ext_wb_we_o;
    logic [4:0]  ext_wb_addr_o;
    logic [31:0] ext_wb_data_o;
    logic        bus_err_o;

    lsu_bus_router_if bus ();

    lsu_bus_router #(.RV32I_DMEM_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .opcode_i(opcode_i), .addr_i(addr_i), .data_w_i(data_w_i),
        .funct3_i(funct3_i), .addr_d_i(addr_d_i),
        .reg_we_i(reg_we_i), .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
        .dmem_addr_o(dmem_addr_o), .dmem_data_w_o(dmem_data_w_o),
        .dmem_mem_we_o(dmem_mem_we_o), .dmem_mem_re_o(dmem_mem_re_o),
        .dmem_funct3_o(dmem_funct3_o),
        .bus(bus.master),
        .stall_o(stall_o), .reg_we_o(reg_we_o), .addr_d_o(addr_d_o),
        .ext_wb_we_o(ext_wb_we_o), .ext_wb_addr_o(ext_wb_addr_o),
        .ext_wb_data_o(ext_wb_data_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    // kind: 0 = transaction start, 1 = external writeback, 2 = error pulse
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        w;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_evt(input int kind, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic w);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            chk("evt_kind", 32'(kind), 32'(e.kind));
            if (e.kind == kind && kind != 2) begin
                chk("evt_addr", a, e.a);
                chk("evt_data", d, e.d);
                if (kind == 0) chk("evt_strb_we", {27'd0, s, w}, {27'd0, e.s, e.w});
            end
        end
    endtask

    // Monitor: registered outputs are stable at the falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.axi_init_o) check_evt(0, bus.axi_addr_o, bus.axi_data_w_o, bus.axi_strb_o, bus.axi_we_o);
            if (ext_wb_we_o)    check_evt(1, {27'd0, ext_wb_addr_o}, ext_wb_data_o, 4'd0, 1'b0);
            if (bus_err_o)      check_evt(2, 32'd0, 32'd0, 4'd0, 1'b0);
        end
    end

    task automatic drive_nop();
        opcode_i = OP_ALU; addr_i = 32'd0; data_w_i = 32'd0; funct3_i = 3'd0;
        addr_d_i = 5'd0; reg_we_i = 1'b0; mem_we_i = 1'b0; mem_re_i = 1'b0;
    endtask

    task automatic drive_ls(input logic [6:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] f3, input logic [4:0] rd);
        opcode_i = op; addr_i = a; data_w_i = wd; funct3_i = f3; addr_d_i = rd;
        reg_we_i = (op == OP_LOAD); mem_we_i = (op == OP_STORE); mem_re_i = (op == OP_LOAD);
    endtask

    function automatic exp_t mk(input int kind, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic w);
        exp_t e;
        e.kind = kind; e.a = a; e.d = d; e.s = s; e.w = w;
        return e;
    endfunction

    // External access with a bridge that answers done_dly cycles after the init cycle (0 = never)
    task automatic ext_access(input string nm, input logic [6:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] f3, input logic [4:0] rd,
                              input int done_dly, input logic [31:0] rdata, input logic err,
                              input logic [3:0] e_strb, input logic [31:0] e_dw,
                              input logic [31:0] e_wb, input int e_stall);
        logic is_st;
        bit   init_seen, fin;
        int   n_since, stall_cnt;
        is_st = (op == OP_STORE);
        drive_ls(op, a, wd, f3, rd);
        sb.push_back(mk(0, a, e_dw, e_strb, is_st));
        if (err || done_dly == 0) sb.push_back(mk(2, 32'd0, 32'd0, 4'd0, 1'b0));
        else if (!is_st)          sb.push_back(mk(1, {27'd0, rd}, e_wb, 4'd0, 1'b0));
        init_seen = 0; fin = 0; n_since = 0; stall_cnt = 0;
        #1;
        chk({nm, "_no_dmem"}, {dmem_addr_o[30:0], dmem_mem_we_o}, 32'd0);
        chk({nm, "_reg_we"}, {26'd0, reg_we_o, addr_d_o}, 32'd0);
        for (int c = 0; c < 300 && !fin; c++) begin
            if (c != 0) #1;
            if (bus.axi_init_o) begin init_seen = 1; n_since = 0; end
            if (stall_o) stall_cnt++;
            else if (init_seen) fin = 1;
            @(negedge clk);
            bus.axi_done_i = 1'b0; bus.axi_err_i = 1'b0; bus.axi_rdata_i = 32'hDEAD_BEEF;
            if (init_seen && !fin) begin
                n_since++;
                if (done_dly != 0 && n_since == done_dly) begin
                    bus.axi_done_i = 1'b1; bus.axi_err_i = err; bus.axi_rdata_i = rdata;
                end
            end
        end
        if (!fin) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got no completion expected completion within 300 cycles", nm);
        end
        chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(e_stall));
        drive_nop();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_nop();
        bus.axi_done_i = 1'b0; bus.axi_err_i = 1'b0; bus.axi_rdata_i = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_axi_addr", bus.axi_addr_o, 32'd0);
        chk("reset_ctrl", {22'd0, bus.axi_init_o, bus.axi_we_o, bus.axi_strb_o, ext_wb_we_o, bus_err_o, stall_o, 1'b0},
            32'd0);
        chk("reset_wb", {ext_wb_addr_o, ext_wb_data_o[26:0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Internal SW at the last DMEM word
        drive_ls(OP_STORE, 32'h0000_0FFC, 32'hDEAD_BEEF, 3'b010, 5'd0);
        #1;
        chk("int_dmem_addr", dmem_addr_o, 32'h0000_0FFC);
        chk("int_dmem_data", dmem_data_w_o, 32'hDEAD_BEEF);
        chk("int_dmem_ctrl", {27'd0, dmem_mem_we_o, dmem_mem_re_o, dmem_funct3_o}, {27'd0, 1'b1, 1'b0, 3'b010});
        chk("int_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        #1 chk("int_no_init", {31'd0, bus.axi_init_o}, 32'd0);
        @(negedge clk);

        // Internal LW keeps pipeline writeback
        drive_ls(OP_LOAD, 32'h0000_0010, 32'd0, 3'b010, 5'd9);
        #1 chk("int_ld_wb", {26'd0, reg_we_o, addr_d_o}, {26'd0, 1'b1, 5'd9});
        @(negedge clk);

        // ALU op with an address beyond the window: plain pass-through, no stall
        opcode_i = OP_ALU; addr_i = 32'h8000_0000; reg_we_i = 1'b1; addr_d_i = 5'd7;
        #1;
        chk("alu_pass", {26'd0, reg_we_o, addr_d_o}, {26'd0, 1'b1, 5'd7});
        chk("alu_quiet", {dmem_addr_o[30:0], stall_o}, 32'd0);
        @(negedge clk);
        drive_nop();
        @(negedge clk);

        // External stores
        ext_access("sb", OP_STORE, 32'h4000_0003, 32'h1234_56A5, 3'b000, 5'd0, 1, 32'd0, 1'b0,
                   4'b1000, 32'hA5A5_A5A5, 32'd0, 3);
        ext_access("sh", OP_STORE, 32'h4000_0002, 32'hFFFF_BEEF, 3'b001, 5'd0, 2, 32'd0, 1'b0,
                   4'b1100, 32'hBEEF_BEEF, 32'd0, 4);
        ext_access("sw", OP_STORE, 32'h4000_0004, 32'hCAFE_F00D, 3'b010, 5'd0, 1, 32'd0, 1'b0,
                   4'b1111, 32'hCAFE_F00D, 32'd0, 3);

        // External loads and extension
        ext_access("lh", OP_LOAD, 32'h4000_0002, 32'd0, 3'b001, 5'd5, 1, 32'h8001_1234, 1'b0,
                   4'b0000, 32'd0, 32'hFFFF_8001, 3);
        ext_access("lhu", OP_LOAD, 32'h4000_0002, 32'd0, 3'b101, 5'd6, 1, 32'h8001_1234, 1'b0,
                   4'b0000, 32'd0, 32'h0000_8001, 3);
        ext_access("lb", OP_LOAD, 32'h4000_0001, 32'd0, 3'b000, 5'd10, 1, 32'h0000_8000, 1'b0,
                   4'b0000, 32'd0, 32'hFFFF_FF80, 3);
        ext_access("lbu", OP_LOAD, 32'h4000_0003, 32'd0, 3'b100, 5'd11, 3, 32'hF100_0000, 1'b0,
                   4'b0000, 32'd0, 32'h0000_00F1, 5);
        ext_access("lw_edge", OP_LOAD, 32'h0000_1000, 32'd0, 3'b010, 5'd31, 1, 32'h1234_5678, 1'b0,
                   4'b0000, 32'd0, 32'h1234_5678, 3);

        // Misaligned external LW: error pulse, no transaction, no stall
        drive_ls(OP_LOAD, 32'h4000_0001, 32'd0, 3'b010, 5'd3);
        sb.push_back(mk(2, 32'd0, 32'd0, 4'd0, 1'b0));
        #1;
        chk("mis_stall_regwe", {30'd0, stall_o, reg_we_o}, 32'd0);
        @(negedge clk);
        drive_nop();
        #1 chk("mis_no_init", {31'd0, bus.axi_init_o}, 32'd0);
        @(negedge clk);

        // Bridge error with done
        ext_access("lw_err", OP_LOAD, 32'h4000_0008, 32'd0, 3'b010, 5'd4, 1, 32'h5555_5555, 1'b1,
                   4'b0000, 32'd0, 32'd0, 3);

`ifdef LSU_ROUTER_TIMEOUT_EN
        // Done withheld: eight WAIT cycles then error
        ext_access("timeout", OP_LOAD, 32'h4000_0000, 32'd0, 3'b100, 5'd12, 0, 32'd0, 1'b0,
                   4'b0000, 32'd0, 32'd0, 10);
`endif

        // Reset during WAIT
        drive_ls(OP_LOAD, 32'h4000_0010, 32'd0, 3'b010, 5'd8);
        sb.push_back(mk(0, 32'h4000_0010, 32'd0, 4'd0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_addr", bus.axi_addr_o, 32'd0);
        chk("midrst_ctrl", {25'd0, bus.axi_init_o, bus.axi_we_o, bus.axi_strb_o, ext_wb_we_o}, 32'd0);
        chk("midrst_err", {31'd0, bus_err_o}, 32'd0);
        drive_nop();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("midrst_idle", {30'd0, stall_o, ext_wb_we_o}, 32'd0);
        @(negedge clk);
        ext_access("post_rst", OP_LOAD, 32'h0000_1000, 32'd0, 3'b000, 5'd2, 1, 32'h0000_007F, 1'b0,
                   4'b0000, 32'd0, 32'h0000_007F, 3);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected end before 200000ns");
        $fatal(1, "watchdog");
    end
endmodule
